// File: rtl/vga_pixel_gen.sv
// Pixel generator: colour bars with a bouncing box behind a 2-stage pipeline, syncs delayed to match.
// Build option PIXGEN_GRID_EN overlays a 32-pixel grey grid on the background.
module vga_pixel_gen #(
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter int          BOX_W     = 32,
  parameter int          BOX_H     = 32,
  parameter int          STEP      = 2,
  parameter int          BAR_SHIFT = 7,
  parameter logic [11:0] BOX_COLOR = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HS_in,
  input  logic        VS_in,
  input  logic [15:0] cnt_x,
  input  logic [15:0] cnt_y,
  input  logic        pause,
  output logic        HS_out,
  output logic        VS_out,
  output logic        de,
  output logic [11:0] rgb,
  output logic        frame_tick
);

  localparam logic [15:0] HA = 16'(H_ACTIVE);
  localparam logic [15:0] VA = 16'(V_ACTIVE);
  localparam logic [15:0] BW = 16'(BOX_W);
  localparam logic [15:0] BH = 16'(BOX_H);
  localparam logic [15:0] ST = 16'(STEP);

  typedef struct packed {
    logic        act;
    logic        hs;
    logic        vs;
    logic [15:0] px;
    logic [15:0] py;
  } s1_t;

  typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y} state_t;

  s1_t         s1;
  state_t      state, state_nx;
  logic [15:0] box_x, box_y, box_x_nx, box_y_nx;
  logic        dir_x, dir_y, dir_x_nx, dir_y_nx;   // 0 = increasing, 1 = decreasing
  logic        tick_nx;
  logic        act_c, in_box, fall;
  logic [2:0]  bar;
  logic [11:0] rgb_c;

  // Stage 1: activity decode and 0-based coordinates
  assign act_c = (cnt_x >= 16'd1) && (cnt_x <= HA) && (cnt_y >= 16'd1) && (cnt_y <= VA);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
    end else begin
      s1.act <= act_c;
      s1.hs  <= HS_in;
      s1.vs  <= VS_in;
      s1.px  <= cnt_x - 16'd1;
      s1.py  <= cnt_y - 16'd1;
    end
  end

  // Stage 2: colour select
  assign in_box = (s1.px >= box_x) && (s1.px < box_x + BW) &&
                  (s1.py >= box_y) && (s1.py < box_y + BH);
  assign bar    = s1.px[BAR_SHIFT+2:BAR_SHIFT];

  always_comb begin
    rgb_c = {{4{bar[0]}}, {4{bar[1]}}, {4{bar[2]}}};
`ifdef PIXGEN_GRID_EN
    if (s1.px[4:0] == 5'd0 || s1.py[4:0] == 5'd0) rgb_c = 12'h888;
`endif
    if (in_box)   rgb_c = BOX_COLOR;
    if (!s1.act)  rgb_c = 12'h000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      HS_out <= 1'b0;
      VS_out <= 1'b0;
      de     <= 1'b0;
      rgb    <= '0;
    end else begin
      HS_out <= s1.hs;
      VS_out <= s1.vs;
      de     <= s1.act;
      rgb    <= rgb_c;
    end
  end

  // The stage-1 VS copy doubles as the edge-detect history
  assign fall = s1.vs & ~VS_in;

  always_comb begin
    state_nx = state;
    tick_nx  = 1'b0;
    box_x_nx = box_x;
    box_y_nx = box_y;
    dir_x_nx = dir_x;
    dir_y_nx = dir_y;
    case (state)
      IDLE: begin
        if (fall) begin
          state_nx = MOVE_X;
          tick_nx  = 1'b1;
        end
      end
      MOVE_X: begin
        state_nx = MOVE_Y;
        if (!pause) begin
          if (!dir_x) begin
            if (box_x + BW + ST > HA) begin
              box_x_nx = HA - BW;
              dir_x_nx = 1'b1;
            end else begin
              box_x_nx = box_x + ST;
            end
          end else if (box_x < ST) begin
            box_x_nx = '0;
            dir_x_nx = 1'b0;
          end else begin
            box_x_nx = box_x - ST;
          end
        end
      end
      MOVE_Y: begin
        state_nx = IDLE;
        if (!pause) begin
          if (!dir_y) begin
            if (box_y + BH + ST > VA) begin
              box_y_nx = VA - BH;
              dir_y_nx = 1'b1;
            end else begin
              box_y_nx = box_y + ST;
            end
          end else if (box_y < ST) begin
            box_y_nx = '0;
            dir_y_nx = 1'b0;
          end else begin
            box_y_nx = box_y - ST;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      frame_tick <= 1'b0;
      box_x      <= '0;
      box_y      <= '0;
      dir_x      <= 1'b0;
      dir_y      <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_tick <= tick_nx;
      box_x      <= box_x_nx;
      box_y      <= box_y_nx;
      dir_x      <= dir_x_nx;
      dir_y      <= dir_y_nx;
    end
  end

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Scoreboard bench for vga_pixel_gen: directed pixels, 400-frame bounce, pause behaviour.
module tb_vga_pixel_gen;
  localparam int HA = 640, VA = 480, BW = 32, BH = 32, ST = 2;

  logic        clk = 1'b0;
  logic        rst, HS_in, VS_in, pause;
  logic [15:0] cnt_x, cnt_y;
  logic        HS_out, VS_out, de, frame_tick;
  logic [11:0] rgb;

  vga_pixel_gen dut (
    .clk(clk), .rst(rst), .HS_in(HS_in), .VS_in(VS_in), .cnt_x(cnt_x), .cnt_y(cnt_y),
    .pause(pause), .HS_out(HS_out), .VS_out(VS_out), .de(de), .rgb(rgb), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        hs, vs, de;
    logic [11:0] rgb;
  } exp_t;

  exp_t q[$];
  int   tq[$];
  int   cyc = 0;
  int   checks = 0, failures = 0;
  bit   mon_on = 1'b0;
  int   bx = 0, by = 0, dxn = 0, dyn = 0;
  exp_t me;
  bit   et;

  typedef struct {
    int          x, y;
    logic        hs;
    logic [11:0] rgb_plain, rgb_grid;
  } vec_t;

  // Hand-computed pixels with the box at (0,0)
  vec_t vecs[14] = '{
    '{1,   100, 1'b1, 12'h000, 12'h888},
    '{129, 100, 1'b0, 12'hF00, 12'h888},
    '{0,   100, 1'b1, 12'h000, 12'h000},
    '{1,   1,   1'b0, 12'hFFF, 12'hFFF},
    '{33,  1,   1'b1, 12'h000, 12'h888},
    '{34,  10,  1'b0, 12'h000, 12'h000},
    '{33,  10,  1'b1, 12'h000, 12'h888},
    '{32,  32,  1'b1, 12'hFFF, 12'hFFF},
    '{641, 1,   1'b0, 12'h000, 12'h000},
    '{640, 480, 1'b1, 12'h00F, 12'h00F},
    '{300, 33,  1'b0, 12'h0F0, 12'h888},
    '{500, 200, 1'b1, 12'hFF0, 12'hFF0},
    '{1,   481, 1'b0, 12'h000, 12'h000},
    '{258, 51,  1'b1, 12'h0F0, 12'h0F0}
  };

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit in_act(int x, int y);
    return (x >= 1 && x <= HA && y >= 1 && y <= VA);
  endfunction

  function automatic logic [11:0] model_rgb(int x, int y);
    int px, py, idx;
    if (!in_act(x, y)) return 12'h000;
    px = x - 1;
    py = y - 1;
    if (px >= bx && px < bx + BW && py >= by && py < by + BH) return 12'hFFF;
`ifdef PIXGEN_GRID_EN
    if (px % 32 == 0 || py % 32 == 0) return 12'h888;
`endif
    idx = px / 128;
    return {((idx & 1) != 0) ? 4'hF : 4'h0, ((idx & 2) != 0) ? 4'hF : 4'h0,
            ((idx & 4) != 0) ? 4'hF : 4'h0};
  endfunction

  task automatic push_exp(int x, int y, logic hs, logic vs, logic [11:0] r);
    exp_t e;
    e.due = cyc + 2;
    e.hs  = hs;
    e.vs  = vs;
    e.de  = in_act(x, y);
    e.rgb = r;
    q.push_back(e);
  endtask

  task automatic drive(int x, int y, logic hs, logic vs);
    @(posedge clk);
    #1;
    cnt_x = 16'(x);
    cnt_y = 16'(y);
    HS_in = hs;
    VS_in = vs;
    push_exp(x, y, hs, vs, model_rgb(x, y));
  endtask

  task automatic model_move();
    if (!pause) begin
      if (dxn == 0) begin
        if (bx + BW + ST > HA) begin bx = HA - BW; dxn = 1; end
        else bx = bx + ST;
      end else if (bx < ST) begin bx = 0; dxn = 0; end
      else bx = bx - ST;
      if (dyn == 0) begin
        if (by + BH + ST > VA) begin by = VA - BH; dyn = 1; end
        else by = by + ST;
      end else if (by < ST) begin by = 0; dyn = 0; end
      else by = by - ST;
    end
  endtask

  task automatic frame();
    drive(0, 0, 1'b0, 1'b0);
    tq.push_back(cyc + 1);
    repeat (3) drive(0, 0, 1'b0, 1'b0);
    drive(0, 0, 1'b1, 1'b1);
    drive(0, 0, 1'b0, 1'b1);
    model_move();
  endtask

  // Pixels straddling every edge of the box
  task automatic probe();
    drive(bx + 1, by + 1, 1'b0, 1'b1);
    drive(bx + BW, by + BH, 1'b1, 1'b1);
    drive(bx + BW + 1, by + 1, 1'b0, 1'b1);
    drive(bx + 1, by + BH + 1, 1'b1, 1'b1);
    drive(bx, by + 1, 1'b0, 1'b1);
    drive(bx + 1, by, 1'b1, 1'b1);
  endtask

  task automatic chk_bit(string name, logic act, logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      et = 1'b0;
      if (tq.size() > 0 && tq[0] == cyc) begin
        et = 1'b1;
        void'(tq.pop_front());
      end
      checks++;
      if (frame_tick !== et) begin
        failures++;
        $display("FAIL frame_tick cyc=%0d: got %b expected %b", cyc, frame_tick, et);
      end
      while (q.size() > 0 && q[0].due <= cyc) begin
        me = q.pop_front();
        checks++;
        if ({HS_out, VS_out, de, rgb} !== {me.hs, me.vs, me.de, me.rgb}) begin
          failures++;
          $display("FAIL pixel cyc=%0d: got hs=%b vs=%b de=%b rgb=%h expected hs=%b vs=%b de=%b rgb=%h",
                   cyc, HS_out, VS_out, de, rgb, me.hs, me.vs, me.de, me.rgb);
        end
      end
    end
  end

  initial begin
    rst   = 1'b1;
    pause = 1'b0;
    HS_in = 1'b1;
    VS_in = 1'b1;
    cnt_x = 16'd5;
    cnt_y = 16'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_bit("reset HS_out", HS_out, 1'b0);
    chk_bit("reset VS_out", VS_out, 1'b0);
    chk_bit("reset de", de, 1'b0);
    chk_bit("reset frame_tick", frame_tick, 1'b0);
    checks++;
    if (rgb !== 12'h000) begin
      failures++;
      $display("FAIL reset rgb: got %h expected 000", rgb);
    end
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_on = 1'b1;
    cnt_x  = 16'd0;
    cnt_y  = 16'd0;
    HS_in  = 1'b0;
    repeat (2) drive(0, 0, 1'b0, 1'b1);

    foreach (vecs[i]) begin
      drive(vecs[i].x, vecs[i].y, vecs[i].hs, 1'b1);
`ifdef PIXGEN_GRID_EN
      q[q.size()-1].rgb = vecs[i].rgb_grid;
`else
      q[q.size()-1].rgb = vecs[i].rgb_plain;
`endif
    end

    for (int f = 0; f < 400; f++) begin
      frame();
      probe();
    end

    pause = 1'b1;
    for (int f = 0; f < 5; f++) begin
      frame();
      probe();
    end
    pause = 1'b0;
    for (int f = 0; f < 3; f++) begin
      frame();
      probe();
    end

    drive(0, 0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0 || tq.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pixel and %0d tick expectations left, expected 0", q.size(), tq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
